thumb_decode_queue: RTL and testbench

//  Buffered, handshaked Thumb decode stage; successor to the single-cycle decoder.

---
 rtl/thumb_decode_queue.sv | 353 +++++++++++++++++++++++++++++++++++
 tb/tb_thumb_decode_queue.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/thumb_decode_queue.sv
// thumb_decode_queue
//   Buffered Thumb decode stage between fetch and execute. Halfwords are
//   accepted into a DEPTH-entry queue. The head entry is decoded
//   combinationally and captured into a registered micro-op bundle, with
//   valid/ready back-pressure on both sides. 32-bit BL prefix/suffix pairs are
//   merged by a two-state FSM. A synchronous flush drops all in-flight state.
//
// Ports
//   clk          clock, all state on rising edge
//   reset        asynchronous active-low reset
//   flush        synchronous drop of queue, BL state and output bundle
//   in_valid     halfword offered by fetch
//   in_ready     queue has a free entry
//   instruction  offered halfword
//   out_valid    bundle valid
//   out_ready    execute consumes the bundle
//   uop          micro-op code (0 branch/nop, 1 ADD, 2 SUB, 4 EOR, 5 CMP,
//                6 LSL, 8 MOV, 9 STR, 10 LDR, 11 BL)
//   num_to_rhs   num replaces the port-1 RHS operand
//   num          immediate or branch offset (halfword units, unshifted)
//   sel_p0/sel_p1/sel_in  register selects
//   explose      undefined or unsupported encoding
//   branch_cond  1111 not a branch, 1110 always, else Thumb condition
//   level        queue occupancy
module thumb_decode_queue #(
  parameter int DEPTH = 4,
  parameter int NUM_W = 32,
  parameter int UOP_W = 5,
  parameter int REG_W = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [15:0]            instruction,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [UOP_W-1:0]       uop,
  output logic                   num_to_rhs,
  output logic [NUM_W-1:0]       num,
  output logic [REG_W-1:0]       sel_p0,
  output logic [REG_W-1:0]       sel_p1,
  output logic [REG_W-1:0]       sel_in,
  output logic                   explose,
  output logic [3:0]             branch_cond,
  output logic [$clog2(DEPTH):0] level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  localparam logic [0:0] ST_FIRST  = 1'b0;
  localparam logic [0:0] ST_SECOND = 1'b1;

  localparam logic [UOP_W-1:0] UOP_NOP = UOP_W'(0);
  localparam logic [UOP_W-1:0] UOP_ADD = UOP_W'(1);
  localparam logic [UOP_W-1:0] UOP_SUB = UOP_W'(2);
  localparam logic [UOP_W-1:0] UOP_EOR = UOP_W'(4);
  localparam logic [UOP_W-1:0] UOP_CMP = UOP_W'(5);
  localparam logic [UOP_W-1:0] UOP_LSL = UOP_W'(6);
  localparam logic [UOP_W-1:0] UOP_MOV = UOP_W'(8);
  localparam logic [UOP_W-1:0] UOP_STR = UOP_W'(9);
  localparam logic [UOP_W-1:0] UOP_LDR = UOP_W'(10);
  localparam logic [UOP_W-1:0] UOP_BL  = UOP_W'(11);

  localparam logic [3:0] COND_NONE = 4'b1111;
  localparam logic [3:0] COND_AL   = 4'b1110;

  // Field extension helpers
  function automatic logic [REG_W-1:0] reg3(input logic [2:0] f);
    logic [REG_W-1:0] r;
    r      = '0;
    r[2:0] = f;
    return r;
  endfunction

  function automatic logic [NUM_W-1:0] zext3(input logic [2:0] f);
    return {{(NUM_W-3){1'b0}}, f};
  endfunction

  function automatic logic [NUM_W-1:0] zext5(input logic [4:0] f);
    return {{(NUM_W-5){1'b0}}, f};
  endfunction

  function automatic logic [NUM_W-1:0] zext8(input logic [7:0] f);
    return {{(NUM_W-8){1'b0}}, f};
  endfunction

  function automatic logic [NUM_W-1:0] sext8(input logic [7:0] f);
    return {{(NUM_W-8){f[7]}}, f};
  endfunction

  function automatic logic [NUM_W-1:0] sext11(input logic [10:0] f);
    return {{(NUM_W-11){f[10]}}, f};
  endfunction

  function automatic logic [NUM_W-1:0] sext22(input logic [21:0] f);
    return {{(NUM_W-22){f[21]}}, f};
  endfunction

  // Queue storage and control state
  logic [15:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [LVL_W-1:0] count_q, count_d;
  logic [0:0]       state_q, state_d;
  logic [10:0]      hi11_q, hi11_d;

  // Output bundle registers
  logic             out_valid_q, out_valid_d;
  logic [UOP_W-1:0] uop_q, uop_d;
  logic             rhs_q, rhs_d;
  logic [NUM_W-1:0] num_q, num_d;
  logic [REG_W-1:0] p0_q, p0_d;
  logic [REG_W-1:0] p1_q, p1_d;
  logic [REG_W-1:0] in_q, in_d;
  logic             exp_q, exp_d;
  logic [3:0]       cond_q, cond_d;

  // Head decode results
  logic [15:0]      head;
  logic             head_vld;
  logic [UOP_W-1:0] dec_uop;
  logic             dec_rhs;
  logic [NUM_W-1:0] dec_num;
  logic [REG_W-1:0] dec_p0;
  logic [REG_W-1:0] dec_p1;
  logic [REG_W-1:0] dec_in;
  logic             dec_exp;
  logic [3:0]       dec_cond;
  logic             dec_prefix;  // BL prefix: pop and latch, no bundle
  logic             dec_hold;    // broken BL pair: emit explose, keep head

  logic load_en;
  logic push;
  logic pop;

  assign head     = mem_q[rd_ptr_q];
  assign head_vld = (count_q != '0);
  assign in_ready = (count_q < FULL_LVL);
  assign load_en  = head_vld & (~out_valid_q | out_ready);
  assign pop      = load_en & ~dec_hold;
  assign push     = in_valid & in_ready & ~flush;

  // Combinational decode of the queue head
  always_comb begin
    dec_uop    = UOP_NOP;
    dec_rhs    = 1'b0;
    dec_num    = '0;
    dec_p0     = '0;
    dec_p1     = '0;
    dec_in     = '0;
    dec_exp    = 1'b0;
    dec_cond   = COND_NONE;
    dec_prefix = 1'b0;
    dec_hold   = 1'b0;

    if (state_q == ST_SECOND) begin
      if (head[15:11] == 5'b11111) begin
        dec_uop  = UOP_BL;
        dec_cond = COND_AL;
        dec_num  = sext22({hi11_q, head[10:0]});
      end else begin
        // The prefix is abandoned; this halfword is decoded on its own next time.
        dec_exp  = 1'b1;
        dec_hold = 1'b1;
      end
    end else if (head[15:6] == 10'b0000000000) begin
      // LSL #0 is a register move and takes priority over the shift form.
      dec_uop = UOP_MOV;
      dec_p0  = reg3(head[5:3]);
      dec_in  = reg3(head[2:0]);
    end else if (head[15:11] == 5'b00000) begin
      dec_uop = UOP_LSL;
      dec_rhs = 1'b1;
      dec_num = zext5(head[10:6]);
      dec_p1  = reg3(head[5:3]);
      dec_in  = reg3(head[2:0]);
    end else if (head[15:11] == 5'b00011) begin
      dec_uop = head[9] ? UOP_SUB : UOP_ADD;
      dec_p1  = reg3(head[5:3]);
      dec_in  = reg3(head[2:0]);
      if (head[10]) begin
        dec_rhs = 1'b1;
        dec_num = zext3(head[8:6]);
      end else begin
        dec_p0 = reg3(head[8:6]);
      end
    end else if (head[15:11] == 5'b00100) begin
      dec_uop = UOP_MOV;
      dec_rhs = 1'b1;
      dec_num = zext8(head[7:0]);
      dec_in  = reg3(head[10:8]);
    end else if (head[15:11] == 5'b00101) begin
      dec_uop = UOP_CMP;
      dec_rhs = 1'b1;
      dec_num = zext8(head[7:0]);
      dec_p1  = reg3(head[10:8]);
    end else if (head[15:12] == 4'b0011) begin
      dec_uop = head[11] ? UOP_SUB : UOP_ADD;
      dec_rhs = 1'b1;
      dec_num = zext8(head[7:0]);
      dec_p1  = reg3(head[10:8]);
      dec_in  = reg3(head[10:8]);
    end else if (head[15:6] == 10'b0100000001) begin
      dec_uop = UOP_EOR;
      dec_p0  = reg3(head[2:0]);
      dec_p1  = reg3(head[5:3]);
      dec_in  = reg3(head[2:0]);
    end else if (head[15:12] == 4'b0110) begin
      // Offset is passed through unscaled; execute applies the word scaling.
      dec_rhs = 1'b1;
      dec_num = zext5(head[10:6]);
      dec_p1  = reg3(head[5:3]);
      if (head[11]) begin
        dec_uop = UOP_LDR;
        dec_in  = reg3(head[2:0]);
      end else begin
        dec_uop = UOP_STR;
        dec_p0  = reg3(head[2:0]);
      end
    end else if (head[15:12] == 4'b1101) begin
      if (head[11:9] == 3'b111) begin
        dec_exp = 1'b1;
      end else begin
        dec_cond = head[11:8];
        dec_num  = sext8(head[7:0]);
      end
    end else if (head[15:11] == 5'b11100) begin
      dec_cond = COND_AL;
      dec_num  = sext11(head[10:0]);
    end else if (head[15:11] == 5'b11110) begin
      dec_prefix = 1'b1;
    end else begin
      dec_exp = 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    state_d     = state_q;
    hi11_d      = hi11_q;
    out_valid_d = out_valid_q;
    uop_d       = uop_q;
    rhs_d       = rhs_q;
    num_d       = num_q;
    p0_d        = p0_q;
    p1_d        = p1_q;
    in_d        = in_q;
    exp_d       = exp_q;
    cond_d      = cond_q;

    if (flush) begin
      rd_ptr_d    = '0;
      wr_ptr_d    = '0;
      count_d     = '0;
      state_d     = ST_FIRST;
      out_valid_d = 1'b0;
      uop_d       = UOP_NOP;
      rhs_d       = 1'b0;
      num_d       = '0;
      p0_d        = '0;
      p1_d        = '0;
      in_d        = '0;
      exp_d       = 1'b0;
      cond_d      = COND_NONE;
    end else begin
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      count_d  = count_q + LVL_W'(push) - LVL_W'(pop);

      if (load_en) begin
        if (dec_prefix) begin
          state_d     = ST_SECOND;
          hi11_d      = head[10:0];
          out_valid_d = 1'b0;
        end else begin
          state_d     = ST_FIRST;
          out_valid_d = 1'b1;
          uop_d       = dec_uop;
          rhs_d       = dec_rhs;
          num_d       = dec_num;
          p0_d        = dec_p0;
          p1_d        = dec_p1;
          in_d        = dec_in;
          exp_d       = dec_exp;
          cond_d      = dec_cond;
        end
      end else if (out_ready) begin
        out_valid_d = 1'b0;
      end
    end
  end

  // Queue storage: data only, no reset needed
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= instruction;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= ST_FIRST;
      hi11_q      <= '0;
      out_valid_q <= 1'b0;
      uop_q       <= UOP_NOP;
      rhs_q       <= 1'b0;
      num_q       <= '0;
      p0_q        <= '0;
      p1_q        <= '0;
      in_q        <= '0;
      exp_q       <= 1'b0;
      cond_q      <= COND_NONE;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      hi11_q      <= hi11_d;
      out_valid_q <= out_valid_d;
      uop_q       <= uop_d;
      rhs_q       <= rhs_d;
      num_q       <= num_d;
      p0_q        <= p0_d;
      p1_q        <= p1_d;
      in_q        <= in_d;
      exp_q       <= exp_d;
      cond_q      <= cond_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign uop         = uop_q;
  assign num_to_rhs  = rhs_q;
  assign num         = num_q;
  assign sel_p0      = p0_q;
  assign sel_p1      = p1_q;
  assign sel_in      = in_q;
  assign explose     = exp_q;
  assign branch_cond = cond_q;
  assign level       = count_q;

endmodule

// File: tb/tb_thumb_decode_queue.sv
// Testbench for thumb_decode_queue: directed scenarios plus a randomized
// stream compared against a halfword-stream reference model.
module tb_thumb_decode_queue;

  typedef logic [54:0] bundle_t;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic        num_to_rhs, explose;
  logic [15:0] instruction;
  logic [4:0]  uop;
  logic [31:0] num;
  logic [3:0]  sel_p0, sel_p1, sel_in, branch_cond;
  logic [2:0]  level;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  logic [15:0] stim_q[$];
  bundle_t     exp_q[$];
  bundle_t     obs_q[$];
  bit          timed_out;

  localparam bundle_t RST_B = {5'd0, 1'b0, 32'd0, 4'd0, 4'd0, 4'd0, 1'b0, 4'hF};
  localparam bundle_t EXPL  = {5'd0, 1'b0, 32'd0, 4'd0, 4'd0, 4'd0, 1'b1, 4'hF};

  bundle_t cur;
  assign cur = {uop, num_to_rhs, num, sel_p0, sel_p1, sel_in, explose, branch_cond};

  always #5 clk = ~clk;

  thumb_decode_queue dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .out_valid(out_valid), .out_ready(out_ready), .uop(uop),
    .num_to_rhs(num_to_rhs), .num(num), .sel_p0(sel_p0), .sel_p1(sel_p1), .sel_in(sel_in),
    .explose(explose), .branch_cond(branch_cond), .level(level)
  );

  // ---------------- reference model ----------------
  function automatic bundle_t mk(int u, int r, int n, int p0, int p1, int pi, int ex, int c);
    bundle_t b;
    b = {u[4:0], r[0], n[31:0], p0[3:0], p1[3:0], pi[3:0], ex[0], c[3:0]};
    return b;
  endfunction

  function automatic int sx(int v, int bits);
    return v - (((v >> (bits - 1)) & 1) * (1 << bits));
  endfunction

  function automatic bundle_t dec1(logic [15:0] h);
    int x, op5, a, b, c, r8, i8, i5, cc, u;
    x = h; op5 = x >> 11;
    a = (x >> 6) & 7; b = (x >> 3) & 7; c = x & 7;
    r8 = (x >> 8) & 7; i8 = x & 255; i5 = (x >> 6) & 31;
    if ((x >> 6) == 0) return mk(8, 0, 0, b, 0, c, 0, 15);
    if (op5 == 0) return mk(6, 1, i5, 0, b, c, 0, 15);
    if (op5 == 3) begin
      u = ((x >> 9) & 1) ? 2 : 1;
      if (((x >> 10) & 1) == 0) return mk(u, 0, 0, a, b, c, 0, 15);
      return mk(u, 1, a, 0, b, c, 0, 15);
    end
    if (op5 == 4) return mk(8, 1, i8, 0, 0, r8, 0, 15);
    if (op5 == 5) return mk(5, 1, i8, 0, r8, 0, 0, 15);
    if (op5 == 6) return mk(1, 1, i8, 0, r8, r8, 0, 15);
    if (op5 == 7) return mk(2, 1, i8, 0, r8, r8, 0, 15);
    if ((x >> 6) == 'h101) return mk(4, 0, 0, c, b, c, 0, 15);
    if (op5 == 12) return mk(9, 1, i5, c, b, 0, 0, 15);
    if (op5 == 13) return mk(10, 1, i5, 0, b, c, 0, 15);
    if ((x >> 12) == 13) begin
      cc = (x >> 8) & 15;
      if (cc >= 14) return EXPL;
      return mk(0, 0, sx(i8, 8), 0, 0, 0, 0, cc);
    end
    if (op5 == 28) return mk(0, 0, sx(x & 2047, 11), 0, 0, 0, 0, 14);
    return EXPL;
  endfunction

  // Whole-stream model: BL pairs merge, a broken pair yields explose and the
  // second halfword is then decoded on its own.
  function automatic void build_expected();
    int i, n, hi, lo;
    exp_q.delete();
    n = stim_q.size();
    i = 0;
    while (i < n) begin
      if ((stim_q[i] >> 11) == 30) begin
        if (i + 1 < n && (stim_q[i+1] >> 11) == 31) begin
          hi = stim_q[i] & 2047; lo = stim_q[i+1] & 2047;
          exp_q.push_back(mk(11, 0, sx((hi << 11) | lo, 22), 0, 0, 0, 0, 14));
          i += 2;
        end else begin
          if (i + 1 < n) exp_q.push_back(EXPL);
          i += 1;
        end
      end else begin
        exp_q.push_back(dec1(stim_q[i]));
        i += 1;
      end
    end
  endfunction

  function automatic logic [15:0] rand_simple();
    logic [15:0] r;
    int cls, op;
    r = 16'($urandom);
    cls = $urandom_range(0, 11);
    case (cls)
      0:  return {5'b00011, r[10:0]};
      1:  return {5'b00000, 5'($urandom_range(2, 31)), r[5:0]};
      2:  return {10'd0, r[5:0]};
      3:  return {3'b001, r[12:0]};
      4:  return {10'b0100000001, r[5:0]};
      5:  return {4'b0110, r[11:0]};
      6:  return {4'b1101, r[11:0]};
      7:  return {5'b11100, r[10:0]};
      8:  return {5'b11111, r[10:0]};
      9: begin
        op = $urandom_range(0, 14);
        if (op >= 1) op++;
        return {6'b010000, 4'(op), r[5:0]};
      end
      10: return {3'b000, 2'($urandom_range(1, 2)), r[10:0]};
      default: return {4'b1011, r[11:0]};
    endcase
  endfunction

  task automatic gen_stream(input int n);
    logic [15:0] r;
    stim_q.delete();
    for (int k = 0; k < n; k++) begin
      r = 16'($urandom);
      case ($urandom_range(0, 5))
        0: begin
          stim_q.push_back({5'b11110, r[10:0]});
          stim_q.push_back({5'b11111, 11'($urandom)});
        end
        1: begin
          stim_q.push_back({5'b11110, r[10:0]});
          stim_q.push_back(rand_simple());
        end
        default: stim_q.push_back(rand_simple());
      endcase
    end
  endtask

  // Drives stim_q and records every consumed bundle into obs_q.
  task automatic run_stream(input bit rnd, input int budget);
    int idx = 0;
    int cyc = 0;
    timed_out = 0;
    obs_q.delete();
    while (1) begin
      if (idx < stim_q.size() && (!rnd || $urandom_range(0, 3) != 0)) begin
        in_valid = 1'b1; instruction = stim_q[idx];
      end else begin
        in_valid = 1'b0; instruction = 16'($urandom);
      end
      out_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (idx >= stim_q.size() && level == 0 && !out_valid) break;
      if (in_valid && in_ready) idx++;
      if (out_valid && out_ready) obs_q.push_back(cur);
      @(posedge clk); #1;
      cyc++;
      if (cyc > budget) begin timed_out = 1; break; end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    @(posedge clk); #1;
    tot_cnt++; if (cur !== RST_B) $display("FAIL rst_bundle got=%h exp=%h", cur, RST_B); else pass_cnt++;
    tot_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got=%b exp=0", out_valid); else pass_cnt++;
    tot_cnt++; if (level !== 3'd0) $display("FAIL rst_level got=%0d exp=0", level); else pass_cnt++;
    tot_cnt++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready got=%b exp=1", in_ready); else pass_cnt++;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_latency();
    bundle_t e;
    e = mk(1, 0, 0, 2, 1, 0, 0, 15);
    out_ready = 1'b1; in_valid = 1'b1; instruction = 16'h1888;
    @(posedge clk); #1;
    in_valid = 1'b0;
    tot_cnt++; if (out_valid !== 1'b0) $display("FAIL lat_early got=%b exp=0", out_valid); else pass_cnt++;
    tot_cnt++; if (level !== 3'd1) $display("FAIL lat_level got=%0d exp=1", level); else pass_cnt++;
    @(posedge clk); #1;
    tot_cnt++; if (out_valid !== 1'b1) $display("FAIL lat_valid got=%b exp=1", out_valid); else pass_cnt++;
    tot_cnt++; if (cur !== e) $display("FAIL lat_add got=%h exp=%h", cur, e); else pass_cnt++;
    @(posedge clk); #1;
    tot_cnt++; if (out_valid !== 1'b0) $display("FAIL lat_drain got=%b exp=0", out_valid); else pass_cnt++;
    out_ready = 1'b0;
  endtask

  task automatic test_directed();
    bundle_t o;
    stim_q = '{16'hD0FE, 16'hE7FF, 16'hF000, 16'hF802, 16'hF000, 16'h1888,
               16'hDE00, 16'h4080, 16'h4059, 16'h3A05, 16'h6A4B};
    exp_q.delete();
    exp_q.push_back(mk(0, 0, -2, 0, 0, 0, 0, 0));
    exp_q.push_back(mk(0, 0, -1, 0, 0, 0, 0, 14));
    exp_q.push_back(mk(11, 0, 2, 0, 0, 0, 0, 14));
    exp_q.push_back(EXPL);
    exp_q.push_back(mk(1, 0, 0, 2, 1, 0, 0, 15));
    exp_q.push_back(EXPL);
    exp_q.push_back(EXPL);
    exp_q.push_back(mk(4, 0, 0, 1, 3, 1, 0, 15));
    exp_q.push_back(mk(2, 1, 5, 0, 2, 2, 0, 15));
    exp_q.push_back(mk(10, 1, 9, 0, 1, 3, 0, 15));
    run_stream(1'b0, 200);
    tot_cnt++; if (timed_out !== 1'b0) $display("FAIL dir_timeout got=%b exp=0", timed_out); else pass_cnt++;
    tot_cnt++; if (obs_q.size() != exp_q.size()) $display("FAIL dir_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); else pass_cnt++;
    for (int k = 0; k < exp_q.size(); k++) begin
      o = (k < obs_q.size()) ? obs_q[k] : 'x;
      tot_cnt++; if (o !== exp_q[k]) $display("FAIL dir_bundle[%0d] got=%h exp=%h", k, o, exp_q[k]); else pass_cnt++;
    end
  endtask

  task automatic test_stall();
    logic [15:0] hw[5];
    bundle_t held, o;
    int acc = 0;
    for (int k = 0; k < 5; k++) hw[k] = {7'b0001100, 3'(k + 1), 3'(k), 3'(4 - k)};
    out_ready = 1'b0;
    for (int c = 0; c < 20; c++) begin
      in_valid = (acc < 5);
      instruction = hw[(acc < 5) ? acc : 0];
      if (in_valid && in_ready) acc++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    tot_cnt++; if (acc != 5) $display("FAIL stall_accepted got=%0d exp=5", acc); else pass_cnt++;
    tot_cnt++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready got=%b exp=0", in_ready); else pass_cnt++;
    tot_cnt++; if (level !== 3'd4) $display("FAIL stall_level got=%0d exp=4", level); else pass_cnt++;
    tot_cnt++; if (out_valid !== 1'b1) $display("FAIL stall_valid got=%b exp=1", out_valid); else pass_cnt++;
    tot_cnt++; if (cur !== dec1(hw[0])) $display("FAIL stall_head got=%h exp=%h", cur, dec1(hw[0])); else pass_cnt++;
    held = dec1(hw[0]);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      tot_cnt++; if (cur !== held) $display("FAIL stall_stable got=%h exp=%h", cur, held); else pass_cnt++;
    end
    obs_q.delete();
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (out_valid) obs_q.push_back(cur);
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    tot_cnt++; if (obs_q.size() != 5) $display("FAIL stall_drain_count got=%0d exp=5", obs_q.size()); else pass_cnt++;
    for (int k = 0; k < 5; k++) begin
      o = (k < obs_q.size()) ? obs_q[k] : 'x;
      tot_cnt++; if (o !== dec1(hw[k])) $display("FAIL stall_order[%0d] got=%h exp=%h", k, o, dec1(hw[k])); else pass_cnt++;
    end
  endtask

  task automatic test_flush();
    bundle_t e;
    int c = 0;
    out_ready = 1'b0;
    in_valid = 1'b1; instruction = 16'h1888;
    while (level != 3'd3 && c < 20) begin
      @(posedge clk); #1;
      c++;
    end
    tot_cnt++; if (level !== 3'd3) $display("FAIL flush_fill got=%0d exp=3", level); else pass_cnt++;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tot_cnt++; if (level !== 3'd0) $display("FAIL flush_level got=%0d exp=0", level); else pass_cnt++;
    tot_cnt++; if (out_valid !== 1'b0) $display("FAIL flush_valid got=%b exp=0", out_valid); else pass_cnt++;
    tot_cnt++; if (in_ready !== 1'b1) $display("FAIL flush_in_ready got=%b exp=1", in_ready); else pass_cnt++;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      tot_cnt++; if (out_valid !== 1'b0) $display("FAIL flush_quiet got=%b exp=0", out_valid); else pass_cnt++;
    end
    e = mk(8, 1, 5, 0, 0, 1, 0, 15);
    in_valid = 1'b1; instruction = 16'h2105;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    tot_cnt++; if (out_valid !== 1'b1 || cur !== e) $display("FAIL flush_after got=%b/%h exp=1/%h", out_valid, cur, e); else pass_cnt++;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_bl();
    out_ready = 1'b1; in_valid = 1'b1; instruction = 16'hF000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    tot_cnt++; if (out_valid !== 1'b0 || level !== 3'd0) $display("FAIL bl_prefix_silent got=%b/%0d exp=0/0", out_valid, level); else pass_cnt++;
    out_ready = 1'b0; in_valid = 1'b1; instruction = 16'h2105;
    @(posedge clk); #1;
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    tot_cnt++; if (cur !== RST_B) $display("FAIL midrst_bundle got=%h exp=%h", cur, RST_B); else pass_cnt++;
    tot_cnt++; if (out_valid !== 1'b0 || level !== 3'd0) $display("FAIL midrst_state got=%b/%0d exp=0/0", out_valid, level); else pass_cnt++;
    @(posedge clk); #1;
    reset = 1'b1;
    out_ready = 1'b1; in_valid = 1'b1; instruction = 16'hF802;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    tot_cnt++; if (out_valid !== 1'b1 || cur !== EXPL) $display("FAIL midrst_lone_suffix got=%b/%h exp=1/%h", out_valid, cur, EXPL); else pass_cnt++;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    bundle_t o;
    for (int r = 0; r < 2; r++) begin
      do_flush();
      gen_stream(120);
      build_expected();
      run_stream(1'b1, 6000);
      tot_cnt++; if (timed_out !== 1'b0) $display("FAIL rnd_timeout got=%b exp=0", timed_out); else pass_cnt++;
      tot_cnt++; if (obs_q.size() != exp_q.size()) $display("FAIL rnd_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); else pass_cnt++;
      for (int k = 0; k < exp_q.size(); k++) begin
        o = (k < obs_q.size()) ? obs_q[k] : 'x;
        tot_cnt++; if (o !== exp_q[k]) $display("FAIL rnd_bundle[%0d] got=%h exp=%h", k, o, exp_q[k]); else pass_cnt++;
      end
    end
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; instruction = 16'h0000;
    #1;
    test_reset();
    test_latency();
    test_directed();
    test_stall();
    test_flush();
    test_reset_mid_bl();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
